// File: rtl/btn_pkg.sv
// btn_pkg: shared button state type, clock constant and cycle-count helper
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} btn_state_t;
  localparam int CLK_HZ = 50_000_000;
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction
endpackage

// File: rtl/button_events_if.sv
// button_events_if: debounced level in, user-input events and press count out
interface button_events_if;
  logic       clean_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;
  modport master (output clean_in, input press_pulse, release_pulse, short_press, long_press, repeat_pulse, held, press_count);
  modport slave (input clean_in, output press_pulse, release_pulse, short_press, long_press, repeat_pulse, held, press_count);
endinterface

// File: rtl/edge_detect.sv
// edge_detect: rising-edge strobe; prev resets high so a level held through reset is not an edge
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk)
    prev <= rst ? 1'b1 : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/button_events.sv
// button_events: turns a debounced level into press/release/short/long/repeat pulses plus a press counter
module button_events
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = ms_to_cycles(500),
  parameter int REPEAT_CYCLES = ms_to_cycles(100)
) (
  input logic clk,
  input logic rst,
  button_events_if.slave bus
);
  localparam int CNT_W = $clog2(LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  btn_state_t       state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [7:0]       count_n;
  logic             rise, press_n, release_n, short_n, long_n, repeat_n;
  edge_detect u_edge (.clk(clk), .rst(rst), .d(bus.clean_in), .rise(rise));
  // release is tested first so it wins over a threshold reached on the same edge
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    count_n   = bus.press_count;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = PRESSED;
        timer_n = '0;
        press_n = 1'b1;
        count_n = bus.press_count + 8'd1;
      end
      PRESSED: if (!bus.clean_in) begin
        state_n   = IDLE;
        release_n = 1'b1;
        short_n   = 1'b1;
      end else if (timer == LONG_LAST) begin
        state_n = LONG_HELD;
        timer_n = '0;
        long_n  = 1'b1;
      end else timer_n = timer + CNT_W'(1);
      LONG_HELD: if (!bus.clean_in) begin
        state_n   = IDLE;
        release_n = 1'b1;
      end else if (timer == REP_LAST) begin
        timer_n  = '0;
        repeat_n = 1'b1;
      end else timer_n = timer + CNT_W'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      bus.press_count   <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_press   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      state             <= state_n;
      timer             <= timer_n;
      bus.press_count   <= count_n;
      bus.press_pulse   <= press_n;
      bus.release_pulse <= release_n;
      bus.short_press   <= short_n;
      bus.long_press    <= long_n;
      bus.repeat_pulse  <= repeat_n;
      bus.held          <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: random and directed stimulus scored against a hold-duration reference model
module tb_button_events;
  localparam int L = 8;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  button_events_if bif();
  button_events #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (.clk(clk), .rst(rst), .bus(bif.slave));
  always #5 clk = ~clk;
  // model: track how many edges the button has been held since the press edge
  initial begin
    bit       active = 0;
    bit       prev = 1;
    int       n = 0;
    logic [7:0] cnt = 0;
    bit p, rl, s, lg, rp;
    forever begin
      @(posedge clk);
      {p, rl, s, lg, rp} = '0;
      if (rst) begin
        active = 0; n = 0; prev = 1; cnt = 0;
      end else begin
        if (!active) begin
          if (bif.clean_in && !prev) begin
            active = 1; n = 0; p = 1; cnt = cnt + 8'd1;
          end
        end else begin
          n++;
          if (!bif.clean_in) begin
            rl = 1; s = (n <= L); active = 0;
          end else begin
            lg = (n == L);
            rp = (n > L) && ((n - L) % R == 0);
          end
        end
        prev = bif.clean_in;
      end
      exp_q.push_back({p, rl, s, lg, rp, active, cnt});
    end
  end
  initial begin
    logic [13:0] act, expv;
    forever begin
      @(posedge clk);
      #1;
      act = {bif.press_pulse, bif.release_pulse, bif.short_press, bif.long_press, bif.repeat_pulse, bif.held, bif.press_count};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t actual=%h", $time, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL outputs t=%0t actual p/r/s/l/rp/h/cnt=%b_%b_%b_%b_%b_%b_%0d required=%b_%b_%b_%b_%b_%b_%0d",
                   $time, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                   expv[13], expv[12], expv[11], expv[10], expv[9], expv[8], expv[7:0]);
        end
      end
    end
  end
  task automatic drive(input bit c, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bif.clean_in = c;
    end
  endtask
  task automatic pulse_rst(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bif.clean_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(0, 2); drive(1, 3); drive(0, 3);
    drive(1, 20); drive(0, 3);
    drive(1, L); drive(0, 3);
    drive(1, L + R); drive(0, 3);
    drive(1, 2);
    pulse_rst(2);
    drive(1, 10); drive(0, 1); drive(1, 3); drive(0, 3);
    for (int i = 0; i < 257; i++) begin
      drive(1, 1); drive(0, 1);
    end
    drive(0, 2);
    drive(1, 10);
    pulse_rst(1);
    drive(1, 3); drive(0, 2);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_rst($urandom_range(1, 2));
      drive(1, $urandom_range(1, 24));
      drive(0, $urandom_range(1, 4));
    end
    drive(0, 3);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
